// File: rtl/insn_queue_mw.sv
// Multi-wide instruction queue between fetch and decode: up to FETCH_W pushes and
// ISSUE_W pops per cycle over a circular buffer, with occupancy count and flush.

module insn_queue_mw_slot #(
    parameter int ILEN = 32,
    parameter int XLEN = 32
) (
    input  logic            vld_i,
    input  logic [ILEN-1:0] ins_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [ILEN-1:0] ins_o,
    output logic [XLEN-1:0] pc_o
);
    // Invalid slots drive zero so decode never sees stale storage.
    assign ins_o = vld_i ? ins_i : '0;
    assign pc_o  = vld_i ? pc_i  : '0;
endmodule

module insn_queue_mw #(
    parameter int ILEN    = 32,
    parameter int XLEN    = 32,
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    localparam int PUSHW  = $clog2(FETCH_W + 1),
    localparam int POPW   = $clog2(ISSUE_W + 1),
    localparam int PTRW   = $clog2(DEPTH),
    localparam int CNTW   = $clog2(DEPTH) + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [PUSHW-1:0]          push_count,
    input  logic [FETCH_W*ILEN-1:0]   push_ins,
    input  logic [FETCH_W*XLEN-1:0]   push_pc,
    output logic                      push_ready,
    output logic [ISSUE_W-1:0]        out_valid,
    output logic [ISSUE_W*ILEN-1:0]   out_ins,
    output logic [ISSUE_W*XLEN-1:0]   out_pc,
    input  logic [POPW-1:0]           pop_count,
    output logic [CNTW-1:0]           count,
    output logic                      queue_empty
);
    logic [ILEN-1:0] ins_q [DEPTH];
    logic [XLEN-1:0] pc_q  [DEPTH];
    logic [PTRW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0] push_n, push_acc, pop_req, eff_pop;

    assign push_ready = (CNTW'(DEPTH) - cnt_q) >= CNTW'(FETCH_W);

    always_comb begin
        push_n   = (CNTW'(push_count) > CNTW'(FETCH_W)) ? CNTW'(FETCH_W) : CNTW'(push_count);
        push_acc = (push_ready && !flush) ? push_n : '0;
        pop_req  = CNTW'(pop_count);
        // Over-popping is a protocol violation; clamp to what is actually held.
        eff_pop  = (pop_req > cnt_q) ? cnt_q : pop_req;
        rd_d     = rd_q + PTRW'(eff_pop);
        wr_d     = wr_q + PTRW'(push_acc);
        cnt_d    = cnt_q + push_acc - eff_pop;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (!reset && CNTW'(i) < push_acc) begin
                ins_q[wr_q + PTRW'(i)] <= push_ins[i*ILEN +: ILEN];
                pc_q[wr_q + PTRW'(i)]  <= push_pc[i*XLEN +: XLEN];
            end
        end
    end

    for (genvar s = 0; s < ISSUE_W; s++) begin : g_slot
        logic [PTRW-1:0] idx;
        assign idx          = rd_q + PTRW'(s);
        assign out_valid[s] = cnt_q > CNTW'(s);
        insn_queue_mw_slot #(.ILEN(ILEN), .XLEN(XLEN)) u_slot (
            .vld_i (out_valid[s]),
            .ins_i (ins_q[idx]),
            .pc_i  (pc_q[idx]),
            .ins_o (out_ins[s*ILEN +: ILEN]),
            .pc_o  (out_pc[s*XLEN +: XLEN])
        );
    end

    assign count       = cnt_q;
    assign queue_empty = (cnt_q == '0);
endmodule

// File: tb/tb_insn_queue_mw.sv
// Directed bench for insn_queue_mw with a queue-based reference model checked
// every cycle, plus literal expectations at key points.

module tb_insn_queue_mw;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  push_count = '0;
    logic [63:0] push_ins = '0;
    logic [63:0] push_pc = '0;
    logic        push_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_ins;
    logic [63:0] out_pc;
    logic [1:0]  pop_count = '0;
    logic [3:0]  count;
    logic        queue_empty;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_ins[$];
    logic [31:0] m_pc[$];

    insn_queue_mw #(.ILEN(32), .XLEN(32), .DEPTH(8), .FETCH_W(2), .ISSUE_W(2)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .push_count(push_count), .push_ins(push_ins), .push_pc(push_pc),
        .push_ready(push_ready), .out_valid(out_valid), .out_ins(out_ins),
        .out_pc(out_pc), .pop_count(pop_count), .count(count),
        .queue_empty(queue_empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of (ins, pc) pairs.
    always @(posedge clock) begin
        if (reset || flush) begin
            m_ins.delete();
            m_pc.delete();
        end else begin
            int sz, np;
            bit rdy;
            sz  = m_ins.size();
            rdy = (8 - sz) >= 2;
            np  = (int'(pop_count) > sz) ? sz : int'(pop_count);
            repeat (np) begin
                void'(m_ins.pop_front());
                void'(m_pc.pop_front());
            end
            if (rdy) begin
                for (int i = 0; i < int'(push_count); i++) begin
                    m_ins.push_back(push_ins[i*32 +: 32]);
                    m_pc.push_back(push_pc[i*32 +: 32]);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            int sz;
            logic [31:0] e_ins0, e_ins1, e_pc0, e_pc1;
            sz     = m_ins.size();
            e_ins0 = (sz > 0) ? m_ins[0] : 32'h0;
            e_pc0  = (sz > 0) ? m_pc[0]  : 32'h0;
            e_ins1 = (sz > 1) ? m_ins[1] : 32'h0;
            e_pc1  = (sz > 1) ? m_pc[1]  : 32'h0;
            chk("m_count", 64'(count), 64'(sz));
            chk("m_valid", 64'(out_valid), 64'({sz > 1, sz > 0}));
            chk("m_empty", 64'(queue_empty), 64'(sz == 0));
            chk("m_ready", 64'(push_ready), 64'((8 - sz) >= 2));
            chk("m_ins", out_ins, {e_ins1, e_ins0});
            chk("m_pc", out_pc, {e_pc1, e_pc0});
            chk("count_le_depth", 64'(count <= 4'd8), 64'd1);
        end
    end

    task automatic step(input int pc, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input int pp, input bit fl);
        push_count = 2'(pc);
        push_ins   = {i1, i0};
        push_pc    = {p1, p0};
        pop_count  = 2'(pp);
        flush      = fl;
        @(posedge clock);
        #1;
        push_count = '0;
        pop_count  = '0;
        flush      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // 1. reset
        do_reset();
        chk_en = 1'b1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_empty", 64'(queue_empty), 64'd1);
        chk("rst_ready", 64'(push_ready), 64'd1);
        chk("rst_ins", out_ins, 64'd0);

        // 2. single group becomes visible next cycle
        step(2, 32'h11, 32'h22, 32'h100, 32'h104, 0, 0);
        chk("p1_valid", 64'(out_valid), 64'd3);
        chk("p1_ins", out_ins, 64'h00000022_00000011);
        chk("p1_pc", out_pc, 64'h00000104_00000100);
        chk("p1_count", 64'(count), 64'd2);

        // 3. fill to 8, then an ignored push
        step(2, 32'h31, 32'h32, 32'h200, 32'h204, 0, 0);
        step(2, 32'h33, 32'h34, 32'h208, 32'h20c, 0, 0);
        chk("c6_ready", 64'(push_ready), 64'd1);
        step(2, 32'h35, 32'h36, 32'h210, 32'h214, 0, 0);
        chk("full_count", 64'(count), 64'd8);
        chk("full_ready", 64'(push_ready), 64'd0);
        step(1, 32'hAA, 32'hBB, 32'h300, 32'h304, 0, 0);
        chk("ign_count", 64'(count), 64'd8);
        chk("ign_slot0", 64'(out_ins[31:0]), 64'h11);
        // drain one so count=7: push_ready must already be low
        step(0, 0, 0, 0, 0, 1, 0);
        chk("c7_ready", 64'(push_ready), 64'd0);

        // 4. wrap-around with simultaneous push/pop
        do_reset();
        step(2, 32'h41, 32'h42, 32'h400, 32'h404, 0, 0);
        step(2, 32'h43, 32'h44, 32'h408, 32'h40c, 0, 0);
        step(2, 32'h45, 32'h46, 32'h410, 32'h414, 0, 0);
        step(2, 32'h47, 32'h48, 32'h418, 32'h41c, 2, 0);
        chk("wr_count", 64'(count), 64'd6);
        chk("wr_slot0", 64'(out_ins[31:0]), 64'h43);
        step(2, 32'h49, 32'h4A, 32'h420, 32'h424, 2, 0);
        chk("wr2_slot0", 64'(out_ins[31:0]), 64'h45);
        step(0, 0, 0, 0, 0, 2, 0);
        chk("wr_emerge67", out_ins, 64'h00000048_00000047);
        step(0, 0, 0, 0, 0, 2, 0);
        chk("wr_emerge01", out_ins, 64'h0000004A_00000049);
        chk("wr_pc01", out_pc, 64'h00000424_00000420);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("c1_count", 64'(count), 64'd1);

        // 5. over-pop clamped while pushing one
        step(1, 32'h55, 32'h0, 32'h500, 32'h0, 2, 0);
        chk("clamp_count", 64'(count), 64'd1);
        chk("clamp_valid", 64'(out_valid), 64'd1);
        chk("clamp_ins", out_ins, 64'h00000000_00000055);

        // 6. flush discards push/pop in the same cycle
        step(2, 32'h61, 32'h62, 32'h600, 32'h604, 0, 0);
        step(2, 32'h63, 32'h64, 32'h608, 32'h60c, 0, 0);
        chk("pre_fl_count", 64'(count), 64'd5);
        step(2, 32'h65, 32'h66, 32'h610, 32'h614, 1, 1);
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(push_ready), 64'd1);
        step(1, 32'h33, 32'h0, 32'h700, 32'h0, 0, 0);
        chk("post_fl_slot0", 64'(out_ins[31:0]), 64'h33);
        chk("post_fl_count", 64'(count), 64'd1);

        // flush together with reset behaves as reset
        step(2, 32'h71, 32'h72, 32'h800, 32'h804, 0, 0);
        reset = 1'b1;
        step(2, 32'h73, 32'h74, 32'h808, 32'h80c, 0, 1);
        reset = 1'b0;
        chk("rstfl_count", 64'(count), 64'd0);

        @(posedge clock);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/insn_queue_mw.md
Name: insn_queue_mw

Overview:
- Parametrised multi-wide instruction buffer between the fetch stage and the ID stage.
- Fetch pushes 0..FETCH_W instructions per cycle, each with its PC. Decode sees the oldest ISSUE_W entries in parallel and pops 0..ISSUE_W per cycle.
- Generalises the existing single-empty-flag, fixed two-instruction queue interface to configurable fetch width, issue width and depth.
- Adds an occupancy count and a pipeline flush.

Parameters:
- ILEN, 32, instruction width in bits.
- XLEN, 32, PC width in bits.
- DEPTH, 8, number of entries. Power of two; must be >= FETCH_W + ISSUE_W.
- FETCH_W, 2, maximum instructions pushed per cycle (>= 1).
- ISSUE_W, 2, maximum instructions presented and popped per cycle (>= 1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (branch mispredict / exception redirect).
- push_count  in  clog2(FETCH_W+1)  number of valid fetch lanes; lanes 0..push_count-1 are valid, lane 0 is oldest.
- push_ins  in  FETCH_W*ILEN  fetch instructions, lane i at bits [i*ILEN +: ILEN].
- push_pc  in  FETCH_W*XLEN  PC per lane.
- push_ready  out  1  queue accepts a full fetch group this cycle.
- out_valid  out  ISSUE_W  thermometer: bit i = (count > i).
- out_ins  out  ISSUE_W*ILEN  oldest entries; slot 0 is oldest.
- out_pc  out  ISSUE_W*XLEN  PCs of the presented entries.
- pop_count  in  clog2(ISSUE_W+1)  entries consumed this cycle, taken from slot 0 upward.
- count  out  clog2(DEPTH+1)  current occupancy.
- queue_empty  out  1  count == 0.

Behaviour:
- One clock; reset is synchronous and active-high.
- Storage:
  - Circular register array with rd_ptr, wr_ptr (clog2(DEPTH) bits, wrap naturally) and count (clog2(DEPTH)+1 bits).
  - Pointers advance modulo DEPTH; entry index = ptr + lane, modulo DEPTH.
- Reset: rd_ptr = wr_ptr = count = 0, so out_valid = 0, queue_empty = 1, push_ready = 1. Storage contents are not reset.
- push_ready:
  - Combinational from registered count: push_ready = (DEPTH - count) >= FETCH_W.
  - Does not account for a same-cycle pop (no fall-through of free space).
- Push:
  - If push_ready && push_count > 0 && !flush, lanes 0..push_count-1 are written at wr_ptr+i and wr_ptr advances by push_count.
  - If push_ready = 0, the push is ignored entirely (all-or-nothing); fetch must hold its lanes.
- Output:
  - out_ins/out_pc slot i = entry at rd_ptr+i, read combinationally from the registers.
  - Slots with out_valid[i] = 0 drive zero.
  - Push-to-visible latency is 1 cycle; no bypass from push to output.
- Pop:
  - eff_pop = min(pop_count, count). A pop_count larger than occupancy is a protocol violation and is clamped.
  - rd_ptr advances by eff_pop.
- Count update: count_next = count + accepted_push - eff_pop. A simultaneous push and pop in the same cycle is legal.
- Flush:
  - Next cycle, rd_ptr = wr_ptr = count = 0.
  - A push or pop in the flush cycle is discarded.
  - Flush and reset together behave as reset.
- Ordering: strict FIFO across lanes and across the wrap from index DEPTH-1 to 0.
- Invariant: count <= DEPTH at all times; the bench asserts it.

Test Plan:
All scenarios use DEPTH=8, FETCH_W=2, ISSUE_W=2.
1. Reset for 2 cycles -> count=0, out_valid=00, queue_empty=1, push_ready=1, out_ins=0.
2. Push push_count=2 with ins 0x11/0x22 and pc 0x100/0x104 -> next cycle out_valid=11, out_ins slot0=0x11, slot1=0x22, out_pc=0x100/0x104, count=2.
3. Push 2 per cycle for 4 cycles with no pop -> count=8, push_ready=0. A fifth push of 0xAA is ignored; count stays 8 and the oldest entry is unchanged.
4. Wrap-around:
   - Reach count=6 with ptrs at 6, then push 2 and pop 2 in the same cycle -> count stays 6, wr_ptr wraps to 0.
   - Pop 2 per cycle thereafter -> instructions emerge in push order across index 7->0.
5. At count=1, pop_count=2 with push_count=1 -> clamped pop of 1. Next cycle count=1 and slot0 = the newly pushed instruction.
6. At count=5, assert flush with push_count=2 and pop_count=1 -> next cycle count=0, out_valid=00, push_ready=1. A subsequent push of 0x33 appears at slot0 one cycle later.
